// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, drives the memory read port, and holds one fetched word for decode.
// Optional macro FETCH_ZERO_HALT_EN: an all-zero fetched word ends the program (state DONE).
module fetch_controller #(
    parameter int          ADDR_WIDTH = 9,
    parameter int          DATA_WIDTH = 24,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] readAddr,
    input  logic [DATA_WIDTH-1:0] readData,
    input  logic                  run,
    input  logic                  stop,
    input  logic                  branchValid,
    input  logic [ADDR_WIDTH-1:0] branchTarget,
    output logic                  instValid,
    input  logic                  instReady,
    output logic [DATA_WIDTH-1:0] instOut,
    output logic [ADDR_WIDTH-1:0] instPc,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] RESET_PC_A = ADDR_WIDTH'(RESET_PC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    vld_q, vld_d;
    logic [DATA_WIDTH-1:0]   inst_q, inst_d;
    logic [ADDR_WIDTH-1:0]   inst_pc_q, inst_pc_d;
    logic                    zero_word;

`ifdef FETCH_ZERO_HALT_EN
    assign zero_word = (readData == '0);
    assign done      = (state_q == DONE);
`else
    assign zero_word = 1'b0;
    assign done      = 1'b0;
`endif

    assign readAddr  = pc_q;
    assign instValid = vld_q;
    assign instOut   = inst_q;
    assign instPc    = inst_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC_A;
            vld_q     <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            vld_q     <= vld_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        vld_d     = vld_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        if (stop) begin
            state_d = IDLE;
            vld_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (branchValid) begin
                        pc_d = branchTarget;
                    end else if (run) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (branchValid) begin
                        pc_d  = branchTarget;
                        vld_d = 1'b0;
                    end else if (!vld_q || instReady) begin
                        // A zero word is never loaded; any pending word is being accepted this cycle.
                        if (zero_word) begin
                            state_d = DONE;
                            vld_d   = 1'b0;
                        end else begin
                            inst_d    = readData;
                            inst_pc_d = pc_q;
                            vld_d     = 1'b1;
                            pc_d      = pc_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    if (vld_q && instReady) begin
                        vld_d = 1'b0;
                    end
                    if (branchValid) begin
                        pc_d = branchTarget;
                    end else if (run) begin
                        pc_d    = RESET_PC_A;
                        vld_d   = 1'b0;
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: expected (pc, word) pairs are queued as stimulus is issued and
// compared on every decode handshake. Define FETCH_ZERO_HALT_EN for both RTL and bench to test the halt build.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  readAddr;
    logic [23:0] readData;
    logic        run, stop, branchValid, instValid, instReady, done;
    logic [8:0]  branchTarget, instPc;
    logic [23:0] instOut;

    logic [23:0] mem [0:511];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;
    int   acc_cnt  = 0;
    int   base;

    fetch_controller #(.ADDR_WIDTH(9), .DATA_WIDTH(24), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .readAddr(readAddr), .readData(readData),
        .run(run), .stop(stop), .branchValid(branchValid), .branchTarget(branchTarget),
        .instValid(instValid), .instReady(instReady), .instOut(instOut),
        .instPc(instPc), .done(done)
    );

    assign readData = mem[readAddr];

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int pc);
        sb_q.push_back('{32'(pc), 32'(mem[pc])});
    endtask

    task automatic wait_accepts(input int target);
        int n = 0;
        while (acc_cnt < target && n < 100) begin
            tick();
            n++;
        end
        if (acc_cnt < target) check_eq("accept_timeout", 32'(acc_cnt), 32'(target));
        instReady = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic pulse_branch(input logic [8:0] tgt);
        branchValid  = 1'b1;
        branchTarget = tgt;
        tick();
        branchValid  = 1'b0;
    endtask

    // Monitor: every handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && instValid && instReady) begin
            if (sb_q.size() > 0) e = sb_q.pop_front();
            else e = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
            check_eq("inst_pc", 32'(instPc), e.pc);
            check_eq("inst_out", 32'(instOut), e.data);
            check_eq("rd_lead", 32'(readAddr), 32'(9'(instPc + 9'd1)));
            acc_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 24'h5A0000 | 24'(i);
        mem[0] = 24'h000011; mem[1] = 24'h000022; mem[2] = 24'h000033; mem[3] = 24'h000044;
        rst = 1'b1; run = 1'b0; stop = 1'b0; branchValid = 1'b0; branchTarget = '0; instReady = 1'b0;
        tick(); tick();
        @(negedge clk);
        check_eq("rst_valid", 32'(instValid), 32'd0);
        check_eq("rst_out", 32'(instOut), 32'd0);
        check_eq("rst_ipc", 32'(instPc), 32'd0);
        check_eq("rst_addr", 32'(readAddr), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Sequential stream of words 0..3
        for (int i = 0; i < 4; i++) push_exp(i);
        base = acc_cnt;
        instReady = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        @(negedge clk);
        check_eq("start_latency", 32'(instValid), 32'd0);
        wait_accepts(base + 4);

        // Backpressure: pc 4 held for three cycles
        repeat (3) begin
            @(negedge clk);
            check_eq("bp_valid", 32'(instValid), 32'd1);
            check_eq("bp_ipc", 32'(instPc), 32'd4);
            check_eq("bp_out", 32'(instOut), 32'(mem[4]));
            check_eq("bp_addr", 32'(readAddr), 32'd5);
            tick();
        end
        for (int i = 4; i < 8; i++) push_exp(i);
        base = acc_cnt;
        instReady = 1'b1;
        wait_accepts(base + 4);

        // Branch to 0x100 while pc 8 is accepted
        push_exp(8);
        for (int i = 9'h100; i < 9'h103; i++) push_exp(i);
        base = acc_cnt;
        instReady = 1'b1;
        pulse_branch(9'h100);
        @(negedge clk);
        check_eq("br_bubble", 32'(instValid), 32'd0);
        wait_accepts(base + 4);

        // Wrap-around from 0x1FE
        pulse_stop();
        @(negedge clk);
        check_eq("stop_valid", 32'(instValid), 32'd0);
        pulse_branch(9'h1FE);
        @(negedge clk);
        check_eq("idle_br_addr", 32'(readAddr), 32'h1FE);
        push_exp(9'h1FE); push_exp(9'h1FF); push_exp(0);
        base = acc_cnt;
        instReady = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        wait_accepts(base + 3);

        // Stop with pc 0xF pending, resume at 0x10
        pulse_stop();
        pulse_branch(9'h00C);
        for (int i = 12; i < 15; i++) push_exp(i);
        base = acc_cnt;
        instReady = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        wait_accepts(base + 3);
        @(negedge clk);
        check_eq("pend_valid", 32'(instValid), 32'd1);
        check_eq("pend_ipc", 32'(instPc), 32'hF);
        check_eq("pend_addr", 32'(readAddr), 32'h10);
        @(posedge clk); #1;
        pulse_stop();
        @(negedge clk);
        check_eq("stop2_valid", 32'(instValid), 32'd0);
        check_eq("stop2_addr", 32'(readAddr), 32'h10);
        tick(); tick();
        @(negedge clk);
        check_eq("idle_nofetch", 32'(instValid), 32'd0);
        check_eq("idle_addr", 32'(readAddr), 32'h10);
        check_eq("idle_done", 32'(done), 32'd0);
        push_exp(9'h10); push_exp(9'h11);
        base = acc_cnt;
        instReady = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        wait_accepts(base + 2);

        // Zero word at address 3
        pulse_stop();
        mem[3] = 24'h000000;
        pulse_branch(9'h000);
`ifdef FETCH_ZERO_HALT_EN
        for (int i = 0; i < 3; i++) push_exp(i);
        base = acc_cnt;
        instReady = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        wait_accepts(base + 3);
        @(negedge clk);
        check_eq("halt_done", 32'(done), 32'd1);
        check_eq("halt_valid", 32'(instValid), 32'd0);
        check_eq("halt_addr", 32'(readAddr), 32'd3);
        @(posedge clk); #1;
        tick();
        @(negedge clk);
        check_eq("halt_hold_addr", 32'(readAddr), 32'd3);
        check_eq("halt_hold_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        push_exp(0); push_exp(1);
        base = acc_cnt;
        instReady = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        @(negedge clk);
        check_eq("restart_done", 32'(done), 32'd0);
        wait_accepts(base + 2);
`else
        for (int i = 0; i < 6; i++) push_exp(i);
        base = acc_cnt;
        instReady = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        wait_accepts(base + 6);
        @(negedge clk);
        check_eq("nohalt_done", 32'(done), 32'd0);
        @(posedge clk); #1;
`endif
        check_eq("sb_left", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of a handshake
        instReady = 1'b1; rst = 1'b1;
        tick();
        @(negedge clk);
        check_eq("mid_rst_valid", 32'(instValid), 32'd0);
        check_eq("mid_rst_out", 32'(instOut), 32'd0);
        check_eq("mid_rst_ipc", 32'(instPc), 32'd0);
        check_eq("mid_rst_addr", 32'(readAddr), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; instReady = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
